core_ctrl: RTL
==============

// Module: core_ctrl
// PURPOSE
//  Multi-cycle sequencer for the single-issue NPC core. Steps each instruction through
//  FETCH -> DECODE -> EXEC -> [MEM] -> WB. Handshakes with the instruction and data memory
//  ports (valid/ready on request and response) and gates register-file, CSR and PC write enables.
//  Consumes decoder control outputs (mem_ren, mem_wen, r_wen, csr_wen1, halt) and emits retire/halt status.
// PARAMETERS
//  TIMEOUT_W   8   width of memory-wait timeout counter; limit = 2**TIMEOUT_W-1 cycles
//  CNT_W       32  width of retired-instruction counter
// PORTS
//  clk            in   1      core clock
//  rst            in   1      synchronous, active-high reset
//  if_req_valid   out  1      fetch request valid (address = current PC)
//  if_req_ready   in   1      fetch request accepted
//  if_resp_valid  in   1      fetch data valid
//  if_resp_ready  out  1      controller accepts fetch data
//  ir_wen         out  1      capture fetched word into instruction register
//  dec_mem_ren    in   1      decoded load
//  dec_mem_wen    in   1      decoded store
//  dec_r_wen      in   1      decoded GPR write
//  dec_csr_wen    in   1      decoded CSR write (CSRRx/ECALL)
//  dec_halt       in   1      decoded EBREAK
//  ls_req_valid   out  1      data request valid
//  ls_req_write   out  1      data request is a store (= dec_mem_wen)
//  ls_req_ready   in   1      data request accepted
//  ls_resp_valid  in   1      data response valid (load data / store ack)
//  ls_resp_ready  out  1      controller accepts data response
//  rf_wen         out  1      GPR write strobe
//  csr_wen        out  1      CSR write strobe
//  pc_wen         out  1      PC update strobe (npc selected elsewhere)
//  retire         out  1      one-cycle pulse per completed instruction
//  inst_cnt       out  CNT_W  retired-instruction count
//  halted         out  1      sticky: EBREAK or timeout reached
//  timeout        out  1      sticky: memory wait exceeded limit
// BEHAVIOUR
//  - States: RESET, IF_REQ, IF_WAIT, DECODE, EXEC, LS_REQ, LS_WAIT, WB, HALT. Registered state;
//    all outputs are decoded Moore-style from state, except rf_wen/csr_wen/ls_req_write (state AND dec_*).
//  - rst=1 at an edge: state<=RESET, inst_cnt<=0, halted<=0, timeout<=0, timer<=0; every strobe/valid is 0
//    in RESET. RESET -> IF_REQ unconditionally next cycle. A reset mid-transaction drops any
//    outstanding response; no ready is asserted in RESET.
//  - IF_REQ: if_req_valid=1, held stable until if_req_ready; on valid&ready -> IF_WAIT.
//  - IF_WAIT: if_resp_ready=1; on if_resp_valid: ir_wen=1 same cycle, -> DECODE. Responses are never
//    accepted in IF_REQ (same-cycle request/response is not supported).
//  - DECODE (1 cycle, dec_* valid from IR): dec_halt -> HALT; else -> EXEC.
//  - EXEC (1 cycle): dec_mem_ren|dec_mem_wen -> LS_REQ; else -> WB. Both set: treat as store.
//  - LS_REQ / LS_WAIT: same handshake rules as IF_REQ / IF_WAIT on the ls_* port; -> WB on ls_resp_valid.
//  - WB (1 cycle): pc_wen=1, retire=1, rf_wen=dec_r_wen, csr_wen=dec_csr_wen; inst_cnt+=1 (wraps
//    at 2**CNT_W); -> IF_REQ. Min latency: 5 cycles ALU op, 7 cycles load/store, with zero-wait memory.
//  - Timer: cleared on entry to IF_REQ/LS_REQ; increments each cycle in IF_REQ, IF_WAIT, LS_REQ, LS_WAIT.
//    At limit with handshake still pending: timeout<=1, halted<=1, -> HALT. A handshake completing
//    in the limit cycle wins (no timeout).
//  - HALT: absorbing until rst; all valids/readies/strobes 0; halted=1.
// STRUCTURE
//  - State encodings and TIMEOUT default as localparams in shared header ctrl_defines.vh
//    (reused by the difftest/trace monitor).
//  - One sub-module: wait_timer (clear, enable, limit-hit output), parameterised by TIMEOUT_W.
// TESTING
//  1. rst 3 cycles, zero-wait memories, ADDI: IF_REQ at cycle 1, rf_wen=1 and pc_wen=1 only at cycle 5,
//     retire once, inst_cnt=1.
//  2. LW with ls_req_ready held low 4 cycles: ls_req_valid stays 1 throughout, ls_req_write=0,
//     rf_wen pulses once after ls_resp_valid, inst_cnt+1.
//  3. SW: ls_req_write=1, rf_wen=0, csr_wen=0 in WB, pc_wen=1.
//  4. EBREAK at 3rd instruction: halted=1 from DECODE+1, inst_cnt=2, no further if_req_valid
//     for 100 cycles.
//  5. TIMEOUT_W=4, if_resp_valid never asserts: timeout=halted=1 after 15 wait cycles;
//     response arriving in cycle 15 instead -> no timeout.
//  6. rst asserted in LS_WAIT: next cycle all outputs 0, inst_cnt=0, late ls_resp_valid ignored,
//     fetch restarts.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared types for the NPC multi-cycle sequencer.
// State encoding and default widths are reused by the trace monitor.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_IF_REQ  = 4'd1,
        S_IF_WAIT = 4'd2,
        S_DECODE  = 4'd3,
        S_EXEC    = 4'd4,
        S_LS_REQ  = 4'd5,
        S_LS_WAIT = 4'd6,
        S_WB      = 4'd7,
        S_HALT    = 4'd8
    } state_e;

    localparam int TIMEOUT_W_DEF = 8;
    localparam int CNT_W_DEF     = 32;

    function automatic logic is_mem_phase(state_e s);
        return (s == S_IF_REQ) || (s == S_IF_WAIT) ||
               (s == S_LS_REQ) || (s == S_LS_WAIT);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait cycle counter; hit marks the last permitted cycle
// of a request/response phase (limit = 2**W-1 cycles).
module wait_timer #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [W-1:0] HIT_VAL = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign hit_o = (cnt_q == HIT_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !hit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// with memory-wait timeout and sticky halt.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = TIMEOUT_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic             if_req_valid,
    input  logic             if_req_ready,
    input  logic             if_resp_valid,
    output logic             if_resp_ready,
    output logic             ir_wen,
    input  logic             dec_mem_ren,
    input  logic             dec_mem_wen,
    input  logic             dec_r_wen,
    input  logic             dec_csr_wen,
    input  logic             dec_halt,
    output logic             ls_req_valid,
    output logic             ls_req_write,
    input  logic             ls_req_ready,
    input  logic             ls_resp_valid,
    output logic             ls_resp_ready,
    output logic             rf_wen,
    output logic             csr_wen,
    output logic             pc_wen,
    output logic             retire,
    output logic [CNT_W-1:0] inst_cnt,
    output logic             halted,
    output logic             timeout
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             timeout_q, timeout_d;
    logic             tmr_en;
    logic             tmr_hit;

    // Counting only in memory phases also clears on every phase entry.
    assign tmr_en = is_mem_phase(state_q);

    wait_timer #(
        .W(TIMEOUT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr_i(!tmr_en),
        .en_i (tmr_en),
        .hit_o(tmr_hit)
    );

    assign inst_cnt = cnt_q;
    assign halted   = halted_q;
    assign timeout  = timeout_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        halted_d      = halted_q;
        timeout_d     = timeout_q;
        if_req_valid  = 1'b0;
        if_resp_ready = 1'b0;
        ir_wen        = 1'b0;
        ls_req_valid  = 1'b0;
        ls_req_write  = 1'b0;
        ls_resp_ready = 1'b0;
        rf_wen        = 1'b0;
        csr_wen       = 1'b0;
        pc_wen        = 1'b0;
        retire        = 1'b0;
        unique case (state_q)
            S_RESET: begin
                state_d = S_IF_REQ;
            end
            S_IF_REQ: begin
                if_req_valid = 1'b1;
                if (if_req_ready) begin
                    state_d = S_IF_WAIT;
                end else if (tmr_hit) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                    halted_d  = 1'b1;
                end
            end
            S_IF_WAIT: begin
                if_resp_ready = 1'b1;
                if (if_resp_valid) begin
                    ir_wen  = 1'b1;
                    state_d = S_DECODE;
                end else if (tmr_hit) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                    halted_d  = 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_halt) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_mem_ren || dec_mem_wen) begin
                    state_d = S_LS_REQ;
                end else begin
                    state_d = S_WB;
                end
            end
            S_LS_REQ: begin
                ls_req_valid = 1'b1;
                ls_req_write = dec_mem_wen;
                if (ls_req_ready) begin
                    state_d = S_LS_WAIT;
                end else if (tmr_hit) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                    halted_d  = 1'b1;
                end
            end
            S_LS_WAIT: begin
                ls_resp_ready = 1'b1;
                if (ls_resp_valid) begin
                    state_d = S_WB;
                end else if (tmr_hit) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                    halted_d  = 1'b1;
                end
            end
            S_WB: begin
                pc_wen  = 1'b1;
                retire  = 1'b1;
                rf_wen  = dec_r_wen;
                csr_wen = dec_csr_wen;
                cnt_d   = cnt_q + 1'b1;
                state_d = S_IF_REQ;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
